// File: rtl/ram_frame_capture_if.sv
// Pixel stream, RAM write port and scanner handshake of the frame capture block.
interface ram_frame_capture_if #(
  parameter int DATA_W = 8
);
  logic              i_sof;
  logic              i_pix_valid;
  logic [DATA_W-1:0] i_pix_data;
  logic              i_scan_busy;
  logic              o_ram_we;
  logic [9:0]        o_ram_addr;
  logic [DATA_W-1:0] o_ram_din;
  logic              o_start_scan;

  // Pixel source / scanner side
  modport master (
    output i_sof, i_pix_valid, i_pix_data, i_scan_busy,
    input  o_ram_we, o_ram_addr, o_ram_din, o_start_scan
  );

  // Capture block side
  modport slave (
    input  i_sof, i_pix_valid, i_pix_data, i_scan_busy,
    output o_ram_we, o_ram_addr, o_ram_din, o_start_scan
  );
endinterface

// File: rtl/ram_frame_capture.sv
// Captures one sensor frame into the debug RAM, kicks the scanner, and holds
// off further capture until the scan has finished.
module ram_frame_capture #(
  parameter int DATA_W   = 8,
  parameter int NPIX     = 576,
  parameter int SCAN_TMO = 15
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                i_arm,
  input  logic                i_continuous,
  input  logic                i_clear_err,
  ram_frame_capture_if.slave  bus,
  output logic                o_busy,
  output logic [15:0]         o_frame_cnt,
  output logic                o_err_overrun,
  output logic                o_err_short,
  output logic                o_err_scan
);

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_WAIT_SOF  = 3'd1;
  localparam logic [2:0] S_CAPTURE   = 3'd2;
  localparam logic [2:0] S_DONE      = 3'd3;
  localparam logic [2:0] S_WAIT_SCAN = 3'd4;

  localparam logic [9:0]    NPIX_L   = 10'(NPIX);
  localparam int            TMO_W    = (SCAN_TMO > 1) ? $clog2(SCAN_TMO) : 1;
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(SCAN_TMO - 1);

  logic [2:0]        state_q, state_d;
  logic [9:0]        cnt_q, cnt_d;
  logic [TMO_W-1:0]  tmo_q, tmo_d;
  logic              phase_q, phase_d;   // 0: waiting for scanner busy, 1: waiting for it to drop
  logic              we_q, we_d;
  logic [9:0]        addr_q, addr_d;
  logic [DATA_W-1:0] din_q, din_d;
  logic              start_q, start_d;
  logic              busy_q, busy_d;
  logic [15:0]       frame_q, frame_d;
  logic              ovr_q, ovr_d;
  logic              short_q, short_d;
  logic              scan_q, scan_d;

  // Next-state, write-port and status decode
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    tmo_d   = tmo_q;
    phase_d = phase_q;
    we_d    = 1'b0;
    addr_d  = addr_q;
    din_d   = din_q;
    start_d = 1'b0;
    frame_d = frame_q;
    ovr_d   = i_clear_err ? 1'b0 : ovr_q;
    short_d = i_clear_err ? 1'b0 : short_q;
    scan_d  = i_clear_err ? 1'b0 : scan_q;

    case (state_q)
      S_IDLE: begin
        if (i_arm) begin
          state_d = S_WAIT_SOF;
          cnt_d   = '0;
        end
      end
      S_WAIT_SOF: begin
        if (bus.i_pix_valid && bus.i_sof) begin
          we_d    = 1'b1;
          addr_d  = '0;
          din_d   = bus.i_pix_data;
          cnt_d   = 10'd1;
          state_d = (NPIX_L == 10'd1) ? S_DONE : S_CAPTURE;
        end
      end
      S_CAPTURE: begin
        if (bus.i_pix_valid) begin
          we_d  = 1'b1;
          din_d = bus.i_pix_data;
          if (bus.i_sof) begin
            // A fresh SOF abandons the partial frame and restarts at address 0.
            short_d = 1'b1;
            addr_d  = '0;
            cnt_d   = 10'd1;
          end else begin
            addr_d = cnt_q;
            cnt_d  = cnt_q + 10'd1;
            if (cnt_q + 10'd1 == NPIX_L) state_d = S_DONE;
          end
        end
      end
      S_DONE: begin
        if (bus.i_pix_valid) ovr_d = 1'b1;
        start_d = 1'b1;
        frame_d = frame_q + 16'd1;
        tmo_d   = '0;
        phase_d = 1'b0;
        state_d = S_WAIT_SCAN;
      end
      S_WAIT_SCAN: begin
        if (bus.i_pix_valid) ovr_d = 1'b1;
        if (!phase_q) begin
          if (bus.i_scan_busy) begin
            phase_d = 1'b1;
          end else if (tmo_q == TMO_LAST) begin
            scan_d  = 1'b1;
            state_d = i_continuous ? S_WAIT_SOF : S_IDLE;
            cnt_d   = '0;
          end else begin
            tmo_d = tmo_q + TMO_W'(1);
          end
        end else if (!bus.i_scan_busy) begin
          state_d = i_continuous ? S_WAIT_SOF : S_IDLE;
          cnt_d   = '0;
        end
      end
      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d != S_IDLE);
  end

  // State and registered outputs, asynchronously cleared
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      tmo_q   <= '0;
      phase_q <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      din_q   <= '0;
      start_q <= 1'b0;
      busy_q  <= 1'b0;
      frame_q <= '0;
      ovr_q   <= 1'b0;
      short_q <= 1'b0;
      scan_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      tmo_q   <= tmo_d;
      phase_q <= phase_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      din_q   <= din_d;
      start_q <= start_d;
      busy_q  <= busy_d;
      frame_q <= frame_d;
      ovr_q   <= ovr_d;
      short_q <= short_d;
      scan_q  <= scan_d;
    end
  end

  assign bus.o_ram_we     = we_q;
  assign bus.o_ram_addr   = addr_q;
  assign bus.o_ram_din    = din_q;
  assign bus.o_start_scan = start_q;
  assign o_busy           = busy_q;
  assign o_frame_cnt      = frame_q;
  assign o_err_overrun    = ovr_q;
  assign o_err_short      = short_q;
  assign o_err_scan       = scan_q;

endmodule

// File: tb/tb_ram_frame_capture.sv
// Testbench for ram_frame_capture: scenario table plus hand-written sequences,
// with a write scoreboard and a simple scanner model.
module tb_ram_frame_capture;
  localparam int NPIX = 576;

  typedef struct packed {
    logic [9:0] addr;
    logic [7:0] data;
  } wr_t;

  typedef struct {
    int pre;       // non-SOF pixels before the SOF
    int gap;       // cycles between valid pixels
    int sof_at;    // length of an abandoned partial frame (0 = none)
    int n_over;    // pixels sent after the frame's last pixel
    int sc_delay;  // scanner cycles from start pulse to busy
    int sc_len;    // scanner busy duration
    bit exp_short;
    bit exp_over;
    bit exp_scan;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic arm = 1'b0;
  logic cont = 1'b0;
  logic clr = 1'b0;
  logic o_busy;
  logic [15:0] o_frame_cnt;
  logic o_err_overrun, o_err_short, o_err_scan;

  ram_frame_capture_if #(.DATA_W(8)) bus ();

  ram_frame_capture #(.DATA_W(8), .NPIX(NPIX), .SCAN_TMO(15)) dut (
    .clk(clk), .rst(rst), .i_arm(arm), .i_continuous(cont), .i_clear_err(clr),
    .bus(bus.slave), .o_busy(o_busy), .o_frame_cnt(o_frame_cnt),
    .o_err_overrun(o_err_overrun), .o_err_short(o_err_short), .o_err_scan(o_err_scan)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;
  int cyc = 0;
  wr_t exp_q[$];
  wr_t e_mon;
  int starts = 0, scan_falls = 0;
  int last_we = 0, start_cyc = 0, scan_fall_cyc = 0, obusy_fall_cyc = 0;
  logic prev_err_scan = 1'b0, prev_sbusy = 1'b0, prev_obusy = 1'b0;
  int scan_delay = 1, scan_len = 10, sc_wait = 0, sc_run = 0;
  int exp_frames = 0;

  function automatic void chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // Scanner model: busy rises scan_delay cycles after the start pulse, for scan_len cycles
  always @(posedge clk) begin
    #1;
    if (!rst) begin
      bus.i_scan_busy = 1'b0;
      sc_wait = 0;
      sc_run = 0;
    end else if (bus.o_start_scan) begin
      sc_wait = scan_delay;
      sc_run = scan_len;
    end else if (sc_wait > 0) begin
      sc_wait--;
      if (sc_wait == 0 && sc_run > 0) bus.i_scan_busy = 1'b1;
    end else if (sc_run > 0) begin
      sc_run--;
      if (sc_run == 0) bus.i_scan_busy = 1'b0;
    end
  end

  // Output monitor and write scoreboard
  always @(negedge clk) begin
    if (rst) begin
      if (bus.o_ram_we) begin
        chk("we_while_scan_busy", int'(bus.i_scan_busy), 0);
        chk("write_expected", int'(exp_q.size() > 0), 1);
        if (exp_q.size() > 0) begin
          e_mon = exp_q.pop_front();
          chk("wr_addr", int'(bus.o_ram_addr), int'(e_mon.addr));
          chk("wr_data", int'(bus.o_ram_din), int'(e_mon.data));
        end
        last_we = cyc;
      end
      if (bus.o_start_scan) begin
        starts++;
        chk("start_after_last_write", cyc - last_we, 1);
        start_cyc = cyc;
      end
      if (o_err_scan && !prev_err_scan) chk("scan_tmo_cycles", cyc - start_cyc, 15);
      if (prev_sbusy && !bus.i_scan_busy) begin
        scan_falls++;
        scan_fall_cyc = cyc;
      end
      if (prev_obusy && !o_busy) obusy_fall_cyc = cyc;
    end
    prev_err_scan = o_err_scan;
    prev_sbusy = bus.i_scan_busy;
    prev_obusy = o_busy;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_pix(input bit sof, input logic [7:0] d, input bit expw,
                          input logic [9:0] a, input int gap);
    wr_t w;
    bus.i_sof = sof;
    bus.i_pix_valid = 1'b1;
    bus.i_pix_data = d;
    if (expw) begin
      w.addr = a;
      w.data = d;
      exp_q.push_back(w);
    end
    tick();
    bus.i_sof = 1'b0;
    bus.i_pix_valid = 1'b0;
    repeat (gap - 1) tick();
  endtask

  task automatic send_frame(input int gap, input logic [7:0] xr);
    logic [9:0] a;
    for (int i = 0; i < NPIX; i++) begin
      a = 10'(i);
      send_pix(i == 0, a[7:0] ^ xr, 1'b1, a, gap);
    end
  endtask

  task automatic pulse_arm();
    arm = 1'b1;
    tick();
    arm = 1'b0;
  endtask

  task automatic wait_idle(input int max);
    int k;
    k = 0;
    while (o_busy && k < max) begin
      tick();
      k++;
    end
    chk("idle_reached", int'(o_busy), 0);
  endtask

  task automatic clear_and_check();
    clr = 1'b1;
    tick();
    clr = 1'b0;
    chk("cleared_overrun", int'(o_err_overrun), 0);
    chk("cleared_short", int'(o_err_short), 0);
    chk("cleared_scan", int'(o_err_scan), 0);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_we"}, int'(bus.o_ram_we), 0);
    chk({tag, "_addr"}, int'(bus.o_ram_addr), 0);
    chk({tag, "_din"}, int'(bus.o_ram_din), 0);
    chk({tag, "_start"}, int'(bus.o_start_scan), 0);
    chk({tag, "_busy"}, int'(o_busy), 0);
    chk({tag, "_frame_cnt"}, int'(o_frame_cnt), 0);
    chk({tag, "_errs"}, int'({o_err_overrun, o_err_short, o_err_scan}), 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete, got running expected finished");
    $fatal(1, "watchdog expired");
  end

  vec_t vecs[4];

  initial begin
    int s0, f0, k;
    logic [9:0] a;

    vecs[0] = '{pre: 0, gap: 1, sof_at: 0,   n_over: 0, sc_delay: 1,  sc_len: 40,
                exp_short: 0, exp_over: 0, exp_scan: 0};
    vecs[1] = '{pre: 5, gap: 3, sof_at: 0,   n_over: 0, sc_delay: 2,  sc_len: 10,
                exp_short: 0, exp_over: 0, exp_scan: 0};
    vecs[2] = '{pre: 0, gap: 1, sof_at: 100, n_over: 0, sc_delay: 1,  sc_len: 10,
                exp_short: 1, exp_over: 0, exp_scan: 0};
    vecs[3] = '{pre: 0, gap: 1, sof_at: 0,   n_over: 3, sc_delay: 20, sc_len: 5,
                exp_short: 0, exp_over: 1, exp_scan: 1};

    bus.i_sof = 1'b0;
    bus.i_pix_valid = 1'b0;
    bus.i_pix_data = '0;
    #3 rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk_all_zero("reset");
    #3 rst = 1'b1;
    tick();

    // Scenario table
    for (int v = 0; v < 4; v++) begin
      scan_delay = vecs[v].sc_delay;
      scan_len = vecs[v].sc_len;
      s0 = starts;
      pulse_arm();
      for (int i = 0; i < vecs[v].pre; i++) send_pix(1'b0, 8'hEE, 1'b0, 10'd0, vecs[v].gap);
      for (int i = 0; i < vecs[v].sof_at; i++) begin
        a = 10'(i);
        send_pix(i == 0, a[7:0] ^ 8'h5A, 1'b1, a, vecs[v].gap);
      end
      send_frame(vecs[v].gap, 8'h00);
      for (int i = 0; i < vecs[v].n_over; i++) send_pix(1'b0, 8'h77, 1'b0, 10'd0, 1);
      exp_frames++;
      wait_idle(200);
      repeat (40) tick();
      chk("frame_cnt", int'(o_frame_cnt), exp_frames);
      chk("start_pulses", starts - s0, 1);
      chk("err_short", int'(o_err_short), int'(vecs[v].exp_short));
      chk("err_overrun", int'(o_err_overrun), int'(vecs[v].exp_over));
      chk("err_scan", int'(o_err_scan), int'(vecs[v].exp_scan));
      if (!vecs[v].exp_scan) chk("busy_release", obusy_fall_cyc - scan_fall_cyc, 1);
      chk("writes_pending", exp_q.size(), 0);
      clear_and_check();
    end

    // Continuous mode: three frames from a single arm
    cont = 1'b1;
    scan_delay = 1;
    scan_len = 578;
    s0 = starts;
    f0 = scan_falls;
    pulse_arm();
    for (int fr = 0; fr < 3; fr++) begin
      send_frame(1, 8'h00);
      if (fr == 2) cont = 1'b0;
      exp_frames++;
      k = 0;
      while (scan_falls < f0 + fr + 1 && k < 1000) begin
        tick();
        k++;
      end
      chk("cont_scan_done", scan_falls, f0 + fr + 1);
    end
    wait_idle(50);
    chk("cont_frame_cnt", int'(o_frame_cnt), exp_frames);
    chk("cont_start_pulses", starts - s0, 3);
    chk("cont_errs", int'({o_err_overrun, o_err_short, o_err_scan}), 0);
    chk("cont_writes_pending", exp_q.size(), 0);

    // Asynchronous reset in the middle of a frame
    scan_delay = 1;
    scan_len = 10;
    s0 = starts;
    pulse_arm();
    for (int i = 0; i < 299; i++) begin
      a = 10'(i);
      send_pix(i == 0, a[7:0], 1'b1, a, 1);
    end
    bus.i_sof = 1'b0;
    bus.i_pix_valid = 1'b1;
    bus.i_pix_data = 8'd43;
    #6 rst = 1'b0;
    #1;
    chk_all_zero("async_reset");
    bus.i_pix_valid = 1'b0;
    exp_frames = 0;
    chk("rst_writes_pending", exp_q.size(), 0);
    exp_q.delete();
    repeat (3) @(posedge clk);
    #4 rst = 1'b1;
    tick();
    repeat (5) tick();
    chk("rst_no_start", starts - s0, 0);
    pulse_arm();
    send_frame(1, 8'h00);
    exp_frames++;
    wait_idle(200);
    repeat (20) tick();
    chk("post_rst_frame_cnt", int'(o_frame_cnt), exp_frames);
    chk("post_rst_start_pulses", starts - s0, 1);
    chk("post_rst_writes_pending", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/ram_frame_capture.md
Name: ram_frame_capture

Overview:
- Upstream neighbour of the RAM scan stage. Collects one speckle-sensor frame of NPIX pixel samples into the 10-bit-addressed debug RAM.
- Pulses the scanner's start input once the frame is complete, then waits for the scan to finish before re-arming.
- Guarantees the scanner never reads a partially written frame and that capture never overwrites a frame that is being scanned.

Parameters:
- DATA_W, 8, pixel sample width
- NPIX, 576, pixels per frame; legal range 1..1023
- SCAN_TMO, 15, max cycles to wait for i_scan_busy to rise after o_start_scan

Ports:
- clk  in  1  single clock, rising edge
- rst  in  1  reset, asynchronous, active-low (0 = reset)
- i_arm  in  1  request one capture; level, sampled in IDLE
- i_continuous  in  1  1 = re-arm automatically after each scan
- i_sof  in  1  start-of-frame strobe, qualified by i_pix_valid
- i_pix_valid  in  1  pixel sample valid this cycle
- i_pix_data  in  DATA_W  pixel sample
- i_scan_busy  in  1  scanner active flag (scanner's debug/busy output)
- i_clear_err  in  1  clears the sticky error flags
- o_ram_we  out  1  RAM write enable
- o_ram_addr  out  10  RAM write address
- o_ram_din  out  DATA_W  RAM write data
- o_start_scan  out  1  one-cycle pulse to the scanner start input
- o_busy  out  1  high in any state other than IDLE
- o_frame_cnt  out  16  completed frames, wraps at 0xFFFF->0
- o_err_overrun  out  1  sticky: valid pixel dropped in DONE or WAIT_SCAN
- o_err_short  out  1  sticky: i_sof arrived mid-frame
- o_err_scan  out  1  sticky: scanner did not start within SCAN_TMO cycles

Behaviour:
- Reset (rst=0, async): state=IDLE. All outputs 0, pixel counter 0, timeout counter 0.
- All outputs are registered.
- States:
  - IDLE -> WAIT_SOF when i_arm=1.
  - WAIT_SOF -> CAPTURE on (i_pix_valid & i_sof); that pixel is written to address 0. Non-SOF pixels in WAIT_SOF are ignored and raise no error.
  - CAPTURE: each valid pixel writes address = pixel counter, then counter+1. The pixel that brings the count to NPIX moves the FSM to DONE.
  - DONE: lasts exactly one cycle. o_start_scan=1, o_frame_cnt+1, state -> WAIT_SCAN.
  - WAIT_SCAN: phase A waits for i_scan_busy=1, counting cycles. If SCAN_TMO cycles pass without busy, set o_err_scan and exit. Phase B waits for i_scan_busy=0, then exits.
  - Exit from WAIT_SCAN goes to WAIT_SOF if i_continuous=1, else IDLE.
- Write latency: a pixel accepted in cycle t produces o_ram_we=1, o_ram_addr and o_ram_din in cycle t+1.
- o_start_scan is asserted in the cycle after the last write (last-pixel write at t+1, pulse at t+2).
- Pixel counter is 10 bits and cleared on entry to WAIT_SOF. Addresses run 0..NPIX-1 and never wrap within a frame.
- SOF mid-frame (CAPTURE, i_pix_valid & i_sof, count>0):
  - set o_err_short
  - write that pixel to address 0, counter=1
  - remain in CAPTURE (frame restarts)
- Valid pixel in DONE or WAIT_SCAN: dropped, o_err_overrun set. No write occurs.
- i_arm deasserted after leaving IDLE has no effect; the capture completes.
- i_clear_err clears all three error flags the next cycle. If a set condition and i_clear_err occur in the same cycle, set wins.
- i_scan_busy already high on entry to WAIT_SCAN counts as phase A satisfied.
- Reset asserted mid-capture: immediate return to IDLE. The partial frame is abandoned and no o_start_scan is issued.
- o_ram_we is never high while i_scan_busy=1, which follows from the FSM ordering.

Test Plan:
- Single frame, NPIX=576:
  - Stimulus: i_arm pulse, then SOF plus 576 consecutive valid pixels with data = addr[7:0].
  - Required: 576 writes to addresses 0..575 with matching data; o_start_scan pulses exactly once, 1 cycle after the last write; o_frame_cnt=1; o_busy stays high until the model scanner drops busy.
- Gapped input:
  - Stimulus: pixels valid every 3rd cycle; 5 non-SOF pixels before SOF.
  - Required: the pre-SOF pixels produce no writes; addresses stay contiguous 0..575; no errors.
- Mid-frame SOF:
  - Stimulus: SOF at pixel 100, then a full 576-pixel frame.
  - Required: o_err_short=1; the second SOF pixel is written at address 0; o_start_scan pulses once, after the second frame's last pixel.
- Overrun and timeout:
  - Stimulus: pixels sent during WAIT_SCAN, with the scanner model holding busy low for 20 cycles.
  - Required: o_err_overrun=1; o_err_scan=1 after 15 cycles; FSM returns to IDLE; i_clear_err clears all flags.
- Continuous mode:
  - Stimulus: i_continuous=1, 3 back-to-back frames, scanner model busy for 578 cycles per scan.
  - Required: o_frame_cnt=3; no write occurs while busy=1; the FSM re-enters WAIT_SOF each time without i_arm.
- Async reset:
  - Stimulus: rst=0 asserted at pixel 300 (not clock-aligned).
  - Required: outputs go to 0 immediately; no o_start_scan is issued; after release, i_arm plus a full frame operates normally from address 0.
